// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: diff = a - b over WIDTH bits, DIGIT bits per clock.
// Start/done handshake; diff and borrow hold until the next operation completes.
module serial_subtractor #(
   parameter int unsigned WIDTH = 256,
   parameter int unsigned DIGIT = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             busy,
   output logic             done
);

   localparam int unsigned D  = WIDTH / DIGIT;
   localparam int unsigned CW = (D > 1) ? $clog2(D) : 1;
   localparam int unsigned SW = DIGIT + 1;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_work_q, a_work_d;
   logic [WIDTH-1:0] b_work_q, b_work_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             bin_q, bin_d;
   logic             borrow_q, borrow_d;
   logic             done_q, done_d;

   logic [SW-1:0]    sub_c;
   logic [WIDTH-1:0] res_shift_c;
   logic             last_c;

   // One digit of subtraction; the extra top bit is the outgoing borrow.
   always_comb begin
      sub_c       = {1'b0, a_work_q[DIGIT-1:0]} - {1'b0, b_work_q[DIGIT-1:0]} - SW'(bin_q);
      res_shift_c = {sub_c[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
      last_c      = (cnt_q == CW'(D - 1));
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start)  state_d = RUN;
         RUN:     if (last_c) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next-state: load on accept, shift one digit per RUN cycle
   always_comb begin
      a_work_d = a_work_q;
      b_work_d = b_work_q;
      res_d    = res_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      bin_d    = bin_q;
      borrow_d = borrow_q;
      done_d   = 1'b0;
      if (state_q == IDLE) begin
         if (start) begin
            a_work_d = a;
            b_work_d = b;
            res_d    = '0;
            cnt_d    = '0;
            bin_d    = 1'b0;
         end
      end else begin
         a_work_d = a_work_q >> DIGIT;
         b_work_d = b_work_q >> DIGIT;
         res_d    = res_shift_c;
         bin_d    = sub_c[DIGIT];
         cnt_d    = cnt_q + CW'(1);
         if (last_c) begin
            diff_d   = res_shift_c;
            borrow_d = sub_c[DIGIT];
            done_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_work_q <= '0;
         b_work_q <= '0;
         res_q    <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         bin_q    <= 1'b0;
         borrow_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         a_work_q <= a_work_d;
         b_work_q <= b_work_d;
         res_q    <= res_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         bin_q    <= bin_d;
         borrow_q <= borrow_d;
         done_q   <= done_d;
      end
   end

   // Outputs come straight from flops
   always_comb begin
      busy   = (state_q == RUN);
      diff   = diff_q;
      borrow = borrow_q;
      done   = done_q;
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed test-plan steps plus random
// operands checked against a plain (WIDTH+1)-bit arithmetic reference.
module tb_serial_subtractor;

   localparam int unsigned WIDTH = 256;
   localparam int unsigned DIGIT = 32;
   localparam int unsigned D     = WIDTH / DIGIT;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             busy;
   logic             done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .diff   (diff),
      .borrow (borrow),
      .busy   (busy),
      .done   (done)
   );

   // Reference: {borrow, diff} is just the (WIDTH+1)-bit difference.
   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      return {1'b0, x} - {1'b0, y};
   endfunction

   function automatic logic [WIDTH-1:0] rand_word();
      logic [WIDTH-1:0] r;
      for (int i = 0; i < int'(WIDTH / 32); i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive start for one accepting edge, then scramble the operand inputs.
   task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      start = 1'b1;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = rand_word();
      b     = rand_word();
   endtask

   // Count edges until done, bounded; done and busy must never overlap.
   task automatic wait_done(output int cyc);
      bit seen = 1'b0;
      cyc = 0;
      while (!seen && cyc < int'(4 * D)) begin
         @(posedge clk);
         #1;
         cyc++;
         chk("done_and_busy", WIDTH'(done & busy), '0);
         if (done) seen = 1'b1;
      end
      chk("done_timeout", WIDTH'(seen), WIDTH'(1));
   endtask

   task automatic run_check(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      int               cyc;
      logic [WIDTH:0]   exp;
      exp = model(x, y);
      launch(x, y);
      chk({tag, "_busy_run"}, WIDTH'(busy), WIDTH'(1));
      wait_done(cyc);
      chk({tag, "_latency"}, WIDTH'(cyc), WIDTH'(D));
      chk({tag, "_diff"}, diff, exp[WIDTH-1:0]);
      chk({tag, "_borrow"}, WIDTH'(borrow), WIDTH'(exp[WIDTH]));
      chk({tag, "_busy_done"}, WIDTH'(busy), '0);
      @(posedge clk);
      #1;
      chk({tag, "_done_pulse"}, WIDTH'(done), '0);
      chk({tag, "_diff_hold"}, diff, exp[WIDTH-1:0]);
   endtask

   initial begin : stim
      int               cyc;
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      logic [WIDTH-1:0] ones;
      ones  = '1;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      #2 rst = 1'b0;
      #1;
      chk("rst_diff", diff, '0);
      chk("rst_borrow", WIDTH'(borrow), '0);
      chk("rst_busy", WIDTH'(busy), '0);
      chk("rst_done", WIDTH'(done), '0);
      #20 rst = 1'b1;
      @(posedge clk);
      #1;

      run_check("a100_b3", WIDTH'(100), WIDTH'(3));
      run_check("a3_b5", WIDTH'(3), WIDTH'(5));
      chk("a3_b5_const", diff, ones - WIDTH'(1));
      run_check("a2p32_b1", WIDTH'(1) << 32, WIDTH'(1));
      chk("a2p32_const", diff, WIDTH'(32'hFFFF_FFFF));
      run_check("a2p224_b1", WIDTH'(1) << 224, WIDTH'(1));
      run_check("a0_b0", '0, '0);
      run_check("a0_b1", '0, WIDTH'(1));
      chk("a0_b1_const", diff, ones);

      // start during RUN is ignored
      launch(WIDTH'(100), WIDTH'(3));
      @(posedge clk);
      #1;
      start = 1'b1;
      a     = WIDTH'(9);
      b     = WIDTH'(6);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(cyc);
      chk("ignore_latency", WIDTH'(cyc + 2), WIDTH'(D));
      chk("ignore_diff", diff, WIDTH'(97));
      chk("ignore_borrow", WIDTH'(borrow), '0);

      // start in the done cycle is accepted; old result holds during RUN
      launch(WIDTH'(12), WIDTH'(5));
      chk("b2b_busy", WIDTH'(busy), WIDTH'(1));
      chk("b2b_done_low", WIDTH'(done), '0);
      chk("b2b_hold_old", diff, WIDTH'(97));
      wait_done(cyc);
      chk("b2b_latency", WIDTH'(cyc), WIDTH'(D));
      chk("b2b_diff", diff, WIDTH'(7));

      // asynchronous reset mid-operation aborts with no done
      launch(WIDTH'(100), WIDTH'(3));
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      #2 rst = 1'b0;
      #1;
      chk("midrst_diff", diff, '0);
      chk("midrst_borrow", WIDTH'(borrow), '0);
      chk("midrst_busy", WIDTH'(busy), '0);
      chk("midrst_done", WIDTH'(done), '0);
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("midrst_no_done", WIDTH'(done), '0);
      end
      rst = 1'b1;
      repeat (D + 2) begin
         @(posedge clk);
         #1;
         chk("postrst_no_done", WIDTH'(done | busy), '0);
      end
      run_check("postrst_a100_b3", WIDTH'(100), WIDTH'(3));

      // random operands, including equal and adjacent pairs
      for (int i = 0; i < 24; i++) begin
         x = rand_word();
         y = rand_word();
         if (i % 6 == 1) y = x;
         if (i % 6 == 2) y = x + WIDTH'(1);
         if (i % 6 == 3) y = x - WIDTH'(1);
         if (i % 6 == 4) x[WIDTH-1:DIGIT] = '0;
         run_check("rand", x, y);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
